// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookups are read combinationally and registered; training comes from the execute-stage resolution port.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        pre_valid,
  output logic        pre_is_branch_taken,
  output logic [31:0] pre_branch_addr,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [31:0]      lk_addr;
  logic             upd_hit;
  logic [1:0]       upd_ctr_d;
  logic             unused_upd_lsb;

  logic        pre_valid_q, pre_valid_d;
  logic        pre_taken_q, pre_taken_d;
  logic [31:0] pre_addr_q,  pre_addr_d;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign fetch_tag      = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx        = update_pc[IDX_W+1:2];
  assign upd_tag        = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_upd_lsb = ^update_pc[1:0];

  // Lookup reads the table before this edge's update lands (read-old, no bypass).
  always_comb begin
    lk_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    lk_taken = lk_hit && ctr_q[fetch_idx][1];
    lk_addr  = lk_taken ? target_q[fetch_idx] : (fetch_pc + 32'd4);
  end

  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_d = ctr_q[upd_idx];
    if (upd_hit) begin
      if (update_taken) begin
        if (ctr_q[upd_idx] != 2'b11) upd_ctr_d = ctr_q[upd_idx] + 2'd1;
      end else begin
        if (ctr_q[upd_idx] != 2'b00) upd_ctr_d = ctr_q[upd_idx] - 2'd1;
      end
    end else begin
      upd_ctr_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (update_en && (upd_hit || update_taken)) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= upd_ctr_d;
    end
  end

  // Tag/target need no reset: an entry is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (update_en && update_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target;
    end
  end

  always_comb begin
    pre_valid_d = 1'b0;
    pre_taken_d = 1'b0;
    pre_addr_d  = 32'd0;
    if (flush) begin
      pre_valid_d = 1'b0;
    end else if (stall) begin
      pre_valid_d = pre_valid_q;
      pre_taken_d = pre_taken_q;
      pre_addr_d  = pre_addr_q;
    end else if (fetch_en) begin
      pre_valid_d = 1'b1;
      pre_taken_d = lk_taken;
      pre_addr_d  = lk_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_valid_q <= 1'b0;
      pre_taken_q <= 1'b0;
      pre_addr_q  <= 32'd0;
    end else begin
      pre_valid_q <= pre_valid_d;
      pre_taken_q <= pre_taken_d;
      pre_addr_q  <= pre_addr_d;
    end
  end

  assign pre_valid           = pre_valid_q;
  assign pre_is_branch_taken = pre_taken_q;
  assign pre_branch_addr     = pre_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: table-level reference model checked every cycle,
// plus directed scenarios pinned with literal expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic        pre_valid;
  logic        pre_is_branch_taken;
  logic [31:0] pre_branch_addr;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .fetch_pc            (fetch_pc),
    .stall               (stall),
    .flush               (flush),
    .pre_valid           (pre_valid),
    .pre_is_branch_taken (pre_is_branch_taken),
    .pre_branch_addr     (pre_branch_addr),
    .update_en           (update_en),
    .update_pc           (update_pc),
    .update_taken        (update_taken),
    .update_target       (update_target)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: 64-entry table, index = word address mod 64, tag = pc / 256
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic        ev;
  logic        et;
  logic [31:0] ea;

  always @(posedge clk or negedge rst_n) begin
    int unsigned idx;
    bit          hit;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      ev = 1'b0; et = 1'b0; ea = 32'd0;
    end else begin
      if (flush) begin
        ev = 1'b0; et = 1'b0; ea = 32'd0;
      end else if (stall) begin
        ev = ev;
      end else if (fetch_en) begin
        idx = (fetch_pc / 4) % 64;
        hit = m_valid[idx] && (m_tag[idx] == fetch_pc / 256);
        ev  = 1'b1;
        et  = hit && (m_ctr[idx] >= 2);
        ea  = et ? m_tgt[idx] : fetch_pc + 32'd4;
      end else begin
        ev = 1'b0; et = 1'b0; ea = 32'd0;
      end
      if (update_en) begin
        idx = (update_pc / 4) % 64;
        hit = m_valid[idx] && (m_tag[idx] == update_pc / 256);
        if (hit && update_taken) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = update_target;
        end else if (hit) begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end else if (update_taken) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = update_pc / 256;
          m_tgt[idx]   = update_target;
          m_ctr[idx]   = 2;
        end
      end
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", {31'd0, pre_valid}, {31'd0, ev});
    chk("model_taken", {31'd0, pre_is_branch_taken}, {31'd0, et});
    chk("model_addr", pre_branch_addr, ea);
  end

  // drivers
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    fetch_en = 1'b0;
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt;
    cyc();
    update_en = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_en = 1'b1; fetch_pc = pc;
    cyc();
    fetch_en = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic t, input logic [31:0] a);
    chk({name, "_valid"}, {31'd0, pre_valid}, {31'd0, v});
    chk({name, "_taken"}, {31'd0, pre_is_branch_taken}, {31'd0, t});
    chk({name, "_addr"}, pre_branch_addr, a);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; fetch_pc = '0; stall = 1'b0; flush = 1'b0;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    repeat (3) cyc();
    expect_out("reset", 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    cyc();

    // cold miss
    lookup(32'h1C00_0000);
    expect_out("cold_miss", 1'b1, 1'b0, 32'h1C00_0004);

    // allocate, saturate, then train back down
    do_update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    lookup(32'h1C00_0010);
    expect_out("alloc_hit", 1'b1, 1'b1, 32'h1C00_0100);
    repeat (3) do_update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    do_update(32'h1C00_0010, 1'b0, 32'h0);
    lookup(32'h1C00_0010);
    expect_out("one_nt", 1'b1, 1'b1, 32'h1C00_0100);
    do_update(32'h1C00_0010, 1'b0, 32'h0);
    lookup(32'h1C00_0010);
    expect_out("two_nt", 1'b1, 1'b0, 32'h1C00_0014);

    // not-taken miss does not allocate
    do_update(32'h1C00_0020, 1'b0, 32'hDEAD_BEEF);
    lookup(32'h1C00_0020);
    expect_out("nt_miss", 1'b1, 1'b0, 32'h1C00_0024);

    // alias on index 0
    do_update(32'h1C00_0000, 1'b1, 32'h1C00_0400);
    lookup(32'h1C00_0000);
    expect_out("alias_own", 1'b1, 1'b1, 32'h1C00_0400);
    lookup(32'h1C00_0100);
    expect_out("alias_miss", 1'b1, 1'b0, 32'h1C00_0104);
    do_update(32'h1C00_0100, 1'b1, 32'h1C00_0800);
    lookup(32'h1C00_0000);
    expect_out("alias_evict", 1'b1, 1'b0, 32'h1C00_0004);

    // stall holds for three cycles while fetch_pc moves
    lookup(32'h1C00_0100);
    expect_out("pre_stall", 1'b1, 1'b1, 32'h1C00_0800);
    stall = 1'b1; fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h1C00_0000 + 32'(i * 4);
      cyc();
      expect_out("stall_hold", 1'b1, 1'b1, 32'h1C00_0800);
    end
    flush = 1'b1;
    cyc();
    expect_out("flush_stall", 1'b0, 1'b0, 32'd0);
    flush = 1'b0; stall = 1'b0; fetch_en = 1'b0;

    // wrap-around on miss
    lookup(32'hFFFF_FFFC);
    expect_out("wrap", 1'b1, 1'b0, 32'h0000_0000);

    // mixed traffic over a small PC set, checked by the model only
    for (int i = 0; i < 200; i++) begin
      fetch_en      = 1'($urandom_range(0, 1));
      fetch_pc      = 32'h1C00_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 1) * 256);
      update_en     = 1'($urandom_range(0, 1));
      update_pc     = 32'h1C00_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 1) * 256);
      update_taken  = 1'($urandom_range(0, 1));
      update_target = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
      stall         = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      cyc();
    end
    fetch_en = 1'b0; update_en = 1'b0; stall = 1'b0; flush = 1'b0;

    // reset mid-stream, with an update pending in the reset cycle
    do_update(32'h1C00_0100, 1'b1, 32'h1C00_0900);
    do_update(32'h1C00_0100, 1'b1, 32'h1C00_0900);
    lookup(32'h1C00_0100);
    expect_out("pre_reset", 1'b1, 1'b1, 32'h1C00_0900);
    update_en = 1'b1; update_pc = 32'h1C00_0040; update_taken = 1'b1; update_target = 32'h1C00_0A00;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 32'd0);
    cyc();
    update_en = 1'b0;
    cyc();
    rst_n = 1'b1;
    lookup(32'h1C00_0100);
    expect_out("post_reset", 1'b1, 1'b0, 32'h1C00_0104);
    lookup(32'h1C00_0040);
    expect_out("reset_upd_drop", 1'b1, 1'b0, 32'h1C00_0044);

    // same-cycle lookup and update: lookup reads old contents
    fetch_en = 1'b1; fetch_pc = 32'h1C00_0010;
    update_en = 1'b1; update_pc = 32'h1C00_0010; update_taken = 1'b1; update_target = 32'h1C00_0200;
    cyc();
    update_en = 1'b0;
    expect_out("rw_old", 1'b1, 1'b0, 32'h1C00_0014);
    cyc();
    fetch_en = 1'b0;
    expect_out("rw_next", 1'b1, 1'b1, 32'h1C00_0200);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
